// File: rtl/irq_plic.sv
// rtl/irq_plic.sv - PLIC with level gateways, priority arbiter and claim/complete (option: IRQ_PLIC_SYNC_EN)
module irq_plic #(
    parameter int NSRC   = 32,
    parameter int PRIO_W = 3,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       sources,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              ext_irq
);

    localparam int WA_W = ADDR_W - 2;
    localparam logic [WA_W-1:0] W_PEND   = WA_W'('h020);
    localparam logic [WA_W-1:0] W_ENABLE = WA_W'('h040);
    localparam logic [WA_W-1:0] W_THRESH = WA_W'('h080);
    localparam logic [WA_W-1:0] W_CLAIM  = WA_W'('h081);

    logic [PRIO_W-1:0] prio [NSRC];
    logic [NSRC-1:0]   enable;
    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   in_service;
    logic [PRIO_W-1:0] threshold;
    logic [NSRC-1:0]   src_q;

`ifdef IRQ_PLIC_SYNC_EN
    logic [NSRC-1:0] sync_1;
    logic [NSRC-1:0] sync_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= sources[NSRC-1:0];
            sync_2 <= sync_1;
        end
    end
    assign src_q = sync_2;
`else
    assign src_q = sources[NSRC-1:0];
`endif

    logic [WA_W-1:0] word;
    logic            sel_prio;
    logic [4:0]      prio_idx;
    logic            rd_en;
    logic            wr_en;
    logic            claim;
    logic            complete;
    logic            unused_addr_lsb;

    assign word            = req_addr[ADDR_W-1:2];
    assign sel_prio        = (req_addr[ADDR_W-1:7] == '0);
    assign prio_idx        = word[4:0];
    assign rd_en           = req_valid && !req_write;
    assign wr_en           = req_valid && req_write;
    assign claim           = rd_en && (word == W_CLAIM);
    assign complete        = wr_en && (word == W_CLAIM);
    assign unused_addr_lsb = ^req_addr[1:0];

    // Strictly-greater scan from ID 1 upward keeps the lowest ID on a priority tie.
    logic [4:0]        best_id;
    logic [PRIO_W-1:0] best_prio;

    always_comb begin
        best_id   = '0;
        best_prio = threshold;
        for (int i = 1; i < NSRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
                best_id   = 5'(i);
                best_prio = prio[i];
            end
        end
    end

    logic [NSRC-1:0] set_mask;
    logic [NSRC-1:0] claim_mask;
    logic [NSRC-1:0] done_mask;

    always_comb begin
        set_mask    = src_q & ~pending & ~in_service;
        set_mask[0] = 1'b0;
        claim_mask  = '0;
        if (claim && (best_id != '0))
            claim_mask[best_id] = 1'b1;
        done_mask = '0;
        if (complete && (req_wdata[31:5] == '0) && (req_wdata[4:0] != '0))
            done_mask[req_wdata[4:0]] = 1'b1;
    end

    logic [31:0] rdata_next;

    always_comb begin
        rdata_next = '0;
        if (rd_en) begin
            if (sel_prio)
                rdata_next = {{(32-PRIO_W){1'b0}}, prio[prio_idx]};
            else if (word == W_PEND)
                rdata_next = pending;
            else if (word == W_ENABLE)
                rdata_next = enable;
            else if (word == W_THRESH)
                rdata_next = {{(32-PRIO_W){1'b0}}, threshold};
            else if (word == W_CLAIM)
                rdata_next = {27'd0, best_id};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++)
                prio[i] <= '0;
            enable     <= '0;
            threshold  <= '0;
            pending    <= '0;
            in_service <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            ext_irq    <= 1'b0;
        end else begin
            resp_valid <= req_valid;
            resp_rdata <= rdata_next;
            ext_irq    <= (best_id != '0);
            // Claim clears after the gateway set so a same-edge re-assert loses.
            pending    <= (pending | set_mask) & ~claim_mask;
            in_service <= (in_service | claim_mask) & ~done_mask;
            if (wr_en) begin
                if (sel_prio && (prio_idx != '0))
                    prio[prio_idx] <= req_wdata[PRIO_W-1:0];
                if (word == W_ENABLE)
                    enable <= {req_wdata[NSRC-1:1], 1'b0};
                if (word == W_THRESH)
                    threshold <= req_wdata[PRIO_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_irq_plic.sv
// tb/tb_irq_plic.sv - directed self-checking bench for irq_plic
module tb_irq_plic;

`ifdef IRQ_PLIC_SYNC_EN
    localparam int SLAT = 2;
`else
    localparam int SLAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sources;
    logic        req_valid;
    logic        req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        ext_irq;

    int n_tests = 0;
    int n_fail  = 0;

    irq_plic dut (
        .clk       (clk),
        .rst       (rst),
        .sources   (sources),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .ext_irq   (ext_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks are entered and left at a falling edge.
    task automatic bus_rd(input logic [11:0] addr, output logic [31:0] data);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_resp_valid", {31'd0, resp_valid}, 32'd1);
        data = resp_rdata;
    endtask

    task automatic bus_wr(input logic [11:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("wr_resp_rdata", resp_rdata, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(addr, d);
        check(tag, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        sources   = '0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        idle(3);
        rst = 1'b0;

        check("rst_irq", {31'd0, ext_irq}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        rd_chk("rst_pending", 12'h080, 32'd0);
        rd_chk("rst_enable", 12'h100, 32'd0);
        rd_chk("rst_thresh", 12'h200, 32'd0);
        rd_chk("rst_claim", 12'h204, 32'd0);

        // single source
        bus_wr(12'h00C, 32'd2);
        bus_wr(12'h100, 32'h8);
        bus_wr(12'h200, 32'd0);
        sources[3] = 1'b1;
        idle(1);
        sources[3] = 1'b0;
        idle(SLAT);
        check("t2_irq_early", {31'd0, ext_irq}, 32'd0);
        rd_chk("t2_pending", 12'h080, 32'h8);
        check("t2_irq_set", {31'd0, ext_irq}, 32'd1);
        rd_chk("t2_claim", 12'h204, 32'd3);
        check("t2_irq_hold", {31'd0, ext_irq}, 32'd1);
        idle(1);
        check("t2_irq_drop", {31'd0, ext_irq}, 32'd0);
        rd_chk("t2_pending_clr", 12'h080, 32'd0);
        bus_wr(12'h204, 32'd3);
        sources[3] = 1'b1;
        idle(1);
        sources[3] = 1'b0;
        idle(SLAT);
        rd_chk("t2_repend", 12'h080, 32'h8);
        rd_chk("t2_claim2", 12'h204, 32'd3);
        bus_wr(12'h204, 32'd3);

        // register boundaries
        bus_wr(12'h00C, 32'hFF);
        rd_chk("prio_mask", 12'h00C, 32'd7);
        bus_wr(12'h000, 32'd5);
        rd_chk("prio0_ro", 12'h000, 32'd0);
        bus_wr(12'h100, 32'hFFFF_FFFF);
        rd_chk("enable_bit0", 12'h100, 32'hFFFF_FFFE);
        rd_chk("unmapped", 12'h300, 32'd0);
        bus_wr(12'h080, 32'hFFFF_FFFF);
        rd_chk("pending_ro", 12'h080, 32'd0);

        // priority and tie-break
        bus_wr(12'h014, 32'd4);
        bus_wr(12'h008, 32'd4);
        bus_wr(12'h01C, 32'd6);
        sources = 32'h0000_00A4;
        idle(2 + SLAT);
        rd_chk("t3_claim_7", 12'h204, 32'd7);
        rd_chk("t3_claim_2", 12'h204, 32'd2);
        rd_chk("t3_claim_5", 12'h204, 32'd5);
        rd_chk("t3_claim_0", 12'h204, 32'd0);
        sources = '0;
        bus_wr(12'h204, 32'd7);
        bus_wr(12'h204, 32'd2);
        bus_wr(12'h204, 32'd5);
        idle(2 + SLAT);
        rd_chk("t3_pending", 12'h080, 32'd0);

        // threshold
        bus_wr(12'h010, 32'd3);
        bus_wr(12'h200, 32'd3);
        sources[4] = 1'b1;
        idle(3 + SLAT);
        check("t4_irq_masked", {31'd0, ext_irq}, 32'd0);
        rd_chk("t4_claim_masked", 12'h204, 32'd0);
        rd_chk("t4_pending_kept", 12'h080, 32'h10);
        bus_wr(12'h200, 32'd2);
        idle(1);
        check("t4_irq", {31'd0, ext_irq}, 32'd1);
        rd_chk("t4_claim", 12'h204, 32'd4);
        sources[4] = 1'b0;
        bus_wr(12'h204, 32'd4);
        bus_wr(12'h200, 32'd0);

        // level re-pend and bogus complete
        bus_wr(12'h004, 32'd1);
        sources[1] = 1'b1;
        idle(2 + SLAT);
        rd_chk("t5_claim", 12'h204, 32'd1);
        bus_wr(12'h204, 32'd9);
        rd_chk("t5_bogus", 12'h080, 32'd0);
        bus_wr(12'h204, 32'd1);
        rd_chk("t5_no_same_edge", 12'h080, 32'd0);
        rd_chk("t5_repend", 12'h080, 32'h2);
        rd_chk("t5_claim2", 12'h204, 32'd1);
        sources[1] = 1'b0;
        bus_wr(12'h204, 32'd1);

        // claim/assert collision
        bus_wr(12'h018, 32'd1);
        sources[6] = 1'b1;
        idle(1);
        sources[6] = 1'b0;
        idle(SLAT + 1);
        sources[6] = 1'b1;
        rd_chk("t6_claim", 12'h204, 32'd6);
        rd_chk("t6_pending", 12'h080, 32'd0);
        idle(SLAT + 1);
        rd_chk("t6_in_service", 12'h204, 32'd0);
        rd_chk("t6_pending2", 12'h080, 32'd0);
        sources[6] = 1'b0;
        bus_wr(12'h204, 32'd6);

        // reset aborts an outstanding response
        sources[6] = 1'b1;
        idle(2 + SLAT);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h204;
        rst       = 1'b1;
        idle(1);
        req_valid = 1'b0;
        check("rst_abort_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_abort_irq", {31'd0, ext_irq}, 32'd0);
        rst        = 1'b0;
        sources[6] = 1'b0;
        rd_chk("rst_abort_enable", 12'h100, 32'd0);
        rd_chk("rst_abort_prio", 12'h018, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
